// File: rtl/clk_div_ratio_sequencer_pkg.sv
// clk_div_ratio_sequencer_pkg: shared state encoding, constants and helpers for the ratio sequencer
package clk_div_ratio_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE,
    GATE,
    LOAD,
    SETTLE,
    DONE
  } state_t;
  localparam logic [7:0] MIN_LEGAL_RATIO = 8'd2;
  localparam int CNT_W = 9;
  function automatic logic [CNT_W-1:0] settle_last(input logic [7:0] r);
    return {r, 1'b0} - 9'd1;
  endfunction
endpackage

// File: rtl/clk_div_ratio_sequencer_rr_arb2.sv
// clk_div_ratio_sequencer_rr_arb2: two-way round-robin arbiter, pointer advances on accept
module clk_div_ratio_sequencer_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt
);
  logic ptr;
  always_comb gnt = ptr ? req[1] : !req[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (accept) ptr <= !gnt;
endmodule

// File: rtl/clk_div_ratio_sequencer.sv
// clk_div_ratio_sequencer: serialises divider ratio changes through a gate/quiet/load/settle sequence
module clk_div_ratio_sequencer
  import clk_div_ratio_sequencer_pkg::*;
#(
  parameter logic [7:0] DEFAULT_RATIO = 8'd2,
  parameter int         QUIET_CYCLES  = 4
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req_valid,
  input  logic [7:0] i_req0_ratio,
  input  logic [7:0] i_req1_ratio,
  output logic [1:0] o_req_ack,
  output logic       o_req_err,
  output logic [7:0] o_div_ratio,
  output logic       o_clk_en,
  output logic       o_busy
);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       ratio_q;
  logic             gnt_q;
  logic             err_q;
  logic             arb_gnt;
  logic             accept;
  logic [7:0]       req_ratio;
  always_comb begin
    accept    = (state == IDLE) && (|i_req_valid);
    req_ratio = arb_gnt ? i_req1_ratio : i_req0_ratio;
    o_req_ack = (state == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    o_req_err = (state == DONE) && err_q;
    o_busy    = state != IDLE;
  end
  clk_div_ratio_sequencer_rr_arb2 u_arb (
    .clk   (i_ref_clk),
    .rst_n (i_rst_n),
    .req   (i_req_valid),
    .accept(accept),
    .gnt   (arb_gnt)
  );
  // o_div_ratio only moves in LOAD, where o_clk_en is still low from GATE
  always_ff @(posedge i_ref_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ratio_q     <= DEFAULT_RATIO;
      gnt_q       <= 1'b0;
      err_q       <= 1'b0;
      o_div_ratio <= DEFAULT_RATIO;
      o_clk_en    <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          gnt_q   <= arb_gnt;
          ratio_q <= req_ratio;
          cnt     <= '0;
          err_q   <= req_ratio < MIN_LEGAL_RATIO;
          if (req_ratio < MIN_LEGAL_RATIO || req_ratio == o_div_ratio) state <= DONE;
          else begin
            o_clk_en <= 1'b0;
            state    <= GATE;
          end
        end
        GATE: begin
          cnt <= cnt + 1'b1;
          if (cnt == QUIET_LAST) state <= LOAD;
        end
        LOAD: begin
          o_div_ratio <= ratio_q;
          o_clk_en    <= 1'b1;
          cnt         <= '0;
          state       <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == settle_last(ratio_q)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_clk_div_ratio_sequencer.sv
// tb_clk_div_ratio_sequencer: directed stimulus with a queue-based scoreboard checked on every ack
module tb_clk_div_ratio_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] valid = 2'b00;
  logic [7:0] r0 = 8'd0;
  logic [7:0] r1 = 8'd0;
  logic [1:0] ack;
  logic       err;
  logic [7:0] ratio;
  logic       en;
  logic       busy;
  typedef struct {
    logic [1:0] ack;
    logic       err;
    logic [7:0] ratio;
    int         busy_n;
    int         en_low;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  clk_div_ratio_sequencer #(.DEFAULT_RATIO(8'd2), .QUIET_CYCLES(4)) dut (
    .i_ref_clk   (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (valid),
    .i_req0_ratio(r0),
    .i_req1_ratio(r1),
    .o_req_ack   (ack),
    .o_req_err   (err),
    .o_div_ratio (ratio),
    .o_clk_en    (en),
    .o_busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  // busy_n = busy cycles up to and including the ack cycle; en_low = busy cycles with enable low
  task automatic push(input logic [1:0] a, input logic e, input logic [7:0] r, input int b, input int l);
    exp_t x;
    x.ack = a;
    x.err = e;
    x.ratio = r;
    x.busy_n = b;
    x.en_low = l;
    q.push_back(x);
  endtask
  task automatic wait_ack(input int idx);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = ack[idx];
    end
    if (!seen) chk($sformatf("ack%0d_timeout", idx), 0, 1);
    valid[idx] = 1'b0;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_ratio"}, int'(ratio), 2);
    chk({tag, "_en"}, int'(en), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask
  logic prev_busy = 1'b0;
  logic prev_en = 1'b1;
  logic [7:0] prev_ratio = 8'd2;
  int busy_n = 0;
  int en_low = 0;
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (busy && !prev_busy) begin
        busy_n = 0;
        en_low = 0;
      end
      if (busy) begin
        busy_n++;
        if (!en) en_low++;
      end
      if (ratio != prev_ratio) chk("ratio_change_while_en", int'(prev_en), 0);
      if (ack != 2'b00) begin
        if (q.size() == 0) chk("unexpected_ack", int'(ack), 0);
        else begin
          x = q.pop_front();
          chk("ack", int'(ack), int'(x.ack));
          chk("err", int'(err), int'(x.err));
          chk("ratio_at_ack", int'(ratio), int'(x.ratio));
          chk("en_at_ack", int'(en), 1);
          chk("busy_cycles", busy_n, x.busy_n);
          chk("en_low_cycles", en_low, x.en_low);
        end
      end
    end
    prev_busy = busy;
    prev_en = en;
    prev_ratio = ratio;
  end
  initial begin
    bit hit;
    repeat (2) @(negedge clk);
    reset_checks("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_checks("after_reset");
    // 2 -> 4: 4 quiet + 1 load + 8 settle cycles, ack in the 14th busy cycle
    push(2'b01, 1'b0, 8'd4, 14, 5);
    r0 = 8'd4; valid[0] = 1'b1;
    wait_ack(0);
    push(2'b01, 1'b0, 8'd4, 1, 0);
    @(negedge clk); valid[0] = 1'b1;
    wait_ack(0);
    push(2'b10, 1'b1, 8'd4, 1, 0);
    @(negedge clk); r1 = 8'd1; valid[1] = 1'b1;
    wait_ack(1);
    push(2'b10, 1'b1, 8'd4, 1, 0);
    @(negedge clk); r1 = 8'd0; valid[1] = 1'b1;
    wait_ack(1);
    // pointer now favours req0
    push(2'b01, 1'b0, 8'd6, 18, 5);
    push(2'b10, 1'b0, 8'd3, 12, 5);
    @(negedge clk); r0 = 8'd6; r1 = 8'd3; valid = 2'b11;
    wait_ack(0);
    wait_ack(1);
    push(2'b01, 1'b0, 8'd3, 1, 0);
    @(negedge clk); r0 = 8'd3; valid[0] = 1'b1;
    wait_ack(0);
    // pointer now favours req1
    push(2'b10, 1'b0, 8'd7, 20, 5);
    push(2'b01, 1'b0, 8'd5, 16, 5);
    @(negedge clk); r0 = 8'd5; r1 = 8'd7; valid = 2'b11;
    wait_ack(1);
    wait_ack(0);
    push(2'b01, 1'b0, 8'd8, 22, 5);
    @(negedge clk); r0 = 8'd8; valid[0] = 1'b1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (ratio == 8'd8);
    end
    chk("reached_settle", int'(hit), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid_reset");
    q.delete();
    push(2'b01, 1'b0, 8'd8, 22, 5);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ack(0);
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
